// File: rtl/dual_issue_queue.sv
// Decoupling instruction queue with a dual-issue selector. Up to two
// pre-decoded instructions enter per cycle. Each cycle the head goes to the
// master pipe and head+1 to the slave pipe when that is legal. A small load
// scoreboard resolves load-use interlocks for both slots.
module dual_issue_queue #(
  parameter int DEPTH    = 16,
  parameter int DATA_W   = 64,
  parameter int LOAD_LAT = 2,
  parameter int DUAL_EN  = 1
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       flush,
  input  logic                       stall,
  input  logic [1:0]                 in_valid,
  input  logic [DATA_W-1:0]          in_data0,
  input  logic [DATA_W-1:0]          in_data1,
  input  logic [20:0]                in_meta0,
  input  logic [20:0]                in_meta1,
  output logic                       in_ready,
  output logic                       iss0_valid,
  output logic [DATA_W-1:0]          iss0_data,
  output logic [20:0]                iss0_meta,
  output logic                       iss1_valid,
  output logic [DATA_W-1:0]          iss1_data,
  output logic [20:0]                iss1_meta,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  // Queue state
  logic [AW-1:0]     r_rd_ptr;
  logic [AW-1:0]     r_wr_ptr;
  logic [CW-1:0]     r_count;
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [20:0]       r_meta [DEPTH];

  // Load scoreboard: slot i holds a load destination issued i+1 cycles ago
  logic [LOAD_LAT-1:0] r_sb_v;
  logic [4:0]          r_sb_a [LOAD_LAT];

  logic [AW-1:0] w_next_ptr;
  logic [20:0]   w_hm;
  logic [20:0]   w_nm;
  logic [CW:0]   w_free;
  logic          w_push0;
  logic          w_push1;
  logic [1:0]    w_push_n;
  logic [1:0]    w_pop_n;
  logic          w_haz0;
  logic          w_haz1;
  logic          w_raw;
  logic          w_iss0;
  logic          w_iss1;

  assign w_next_ptr = r_rd_ptr + AW'(1);
  assign w_hm       = r_meta[r_rd_ptr];
  assign w_nm       = r_meta[w_next_ptr];

  // Space check uses registered count only; a same-cycle pop gives no credit
  assign w_free   = (CW+1)'(DEPTH) - {1'b0, r_count};
  assign in_ready = (w_free >= (CW+1)'(2));
  assign w_push0  = in_valid[0] & in_ready & ~flush;
  assign w_push1  = in_valid[1] & in_valid[0] & in_ready & ~flush;
  assign w_push_n = {1'b0, w_push0} + {1'b0, w_push1};

  // Scoreboard lookup for head and head+1 (rt only when the op reads it)
  always_comb begin
    w_haz0 = 1'b0;
    w_haz1 = 1'b0;
    for (int i = 0; i < LOAD_LAT; i++) begin
      w_haz0 = w_haz0 | (r_sb_v[i] & (r_sb_a[i] != 5'd0) &
               ((r_sb_a[i] == w_hm[4:0]) | (w_hm[20] & (r_sb_a[i] == w_hm[9:5]))));
      w_haz1 = w_haz1 | (r_sb_v[i] & (r_sb_a[i] != 5'd0) &
               ((r_sb_a[i] == w_nm[4:0]) | (w_nm[20] & (r_sb_a[i] == w_nm[9:5]))));
    end
  end

  // head+1 reads the register the head writes: cannot pair them
  assign w_raw = w_hm[15] & (w_hm[14:10] != 5'd0) &
                 ((w_nm[4:0] == w_hm[14:10]) | (w_nm[20] & (w_nm[9:5] == w_hm[14:10])));

  assign w_iss0 = (r_count != CW'(0)) & ~stall & ~flush & ~w_haz0;
  assign w_iss1 = (DUAL_EN != 0) & w_iss0 & (r_count >= CW'(2)) & ~w_haz1 &
                  ~w_nm[18] & ~w_nm[17] & ~w_nm[19] & ~w_raw;
  assign w_pop_n = {1'b0, w_iss0} + {1'b0, w_iss1};

  assign iss0_valid = w_iss0;
  assign iss0_data  = r_data[r_rd_ptr];
  assign iss0_meta  = w_hm;
  assign iss1_valid = w_iss1;
  assign iss1_data  = r_data[w_next_ptr];
  assign iss1_meta  = w_nm;
  assign count      = r_count;

  // Pointer and occupancy update; flush empties the queue
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_rd_ptr <= r_rd_ptr + AW'(w_pop_n);
      r_wr_ptr <= r_wr_ptr + AW'(w_push_n);
      r_count  <= r_count + CW'(w_push_n) - CW'(w_pop_n);
    end
  end

  // Payload/meta storage write; contents are don't-care until pushed
  always_ff @(posedge clk) begin
    if (w_push0) begin
      r_data[r_wr_ptr] <= in_data0;
      r_meta[r_wr_ptr] <= in_meta0;
    end
    if (w_push1) begin
      r_data[r_wr_ptr + AW'(1)] <= in_data1;
      r_meta[r_wr_ptr + AW'(1)] <= in_meta1;
    end
  end

  // Scoreboard shift: new entry from issued head load, holds under stall
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sb_v <= '0;
      for (int i = 0; i < LOAD_LAT; i++) r_sb_a[i] <= 5'd0;
    end else if (flush) begin
      r_sb_v <= '0;
      for (int i = 0; i < LOAD_LAT; i++) r_sb_a[i] <= 5'd0;
    end else if (!stall) begin
      for (int i = LOAD_LAT-1; i > 0; i--) begin
        r_sb_v[i] <= r_sb_v[i-1];
        r_sb_a[i] <= r_sb_a[i-1];
      end
      r_sb_v[0] <= w_iss0 & w_hm[16] & w_hm[15];
      r_sb_a[0] <= w_hm[14:10];
    end else begin
      r_sb_v <= r_sb_v;
    end
  end

endmodule

// File: tb/tb_dual_issue_queue.sv
// Directed bench for dual_issue_queue: pairing, RAW and load-use interlocks,
// fill/drain across pointer wrap, flush, slave restrictions, async reset.
module tb_dual_issue_queue;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic        stall;
  logic [1:0]  in_valid;
  logic [63:0] in_data0, in_data1;
  logic [20:0] in_meta0, in_meta1;
  logic        in_ready, iss0_valid, iss1_valid;
  logic [63:0] iss0_data, iss1_data;
  logic [20:0] iss0_meta, iss1_meta;
  logic [4:0]  count;
  logic        se_in_ready, se_iss0_valid, se_iss1_valid;
  logic [63:0] se_iss0_data, se_iss1_data;
  logic [20:0] se_iss0_meta, se_iss1_meta;
  logic [4:0]  se_count;

  int n_tests = 0;
  int n_fail  = 0;
  int idx;

  always #5 clk = ~clk;

  dual_issue_queue #(.DEPTH(16), .DATA_W(64), .LOAD_LAT(2), .DUAL_EN(1)) u_dut (
    .clk(clk), .resetn(resetn), .flush(flush), .stall(stall), .in_valid(in_valid),
    .in_data0(in_data0), .in_data1(in_data1), .in_meta0(in_meta0), .in_meta1(in_meta1),
    .in_ready(in_ready), .iss0_valid(iss0_valid), .iss0_data(iss0_data),
    .iss0_meta(iss0_meta), .iss1_valid(iss1_valid), .iss1_data(iss1_data),
    .iss1_meta(iss1_meta), .count(count));

  dual_issue_queue #(.DEPTH(16), .DATA_W(64), .LOAD_LAT(2), .DUAL_EN(0)) u_se (
    .clk(clk), .resetn(resetn), .flush(flush), .stall(stall), .in_valid(in_valid),
    .in_data0(in_data0), .in_data1(in_data1), .in_meta0(in_meta0), .in_meta1(in_meta1),
    .in_ready(se_in_ready), .iss0_valid(se_iss0_valid), .iss0_data(se_iss0_data),
    .iss0_meta(se_iss0_meta), .iss1_valid(se_iss1_valid), .iss1_data(se_iss1_data),
    .iss1_meta(se_iss1_meta), .count(se_count));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [20:0] mk(input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] wd, input logic wen, input logic ld,
                                     input logic mem, input logic br, input logic hilo,
                                     input logic urt);
    return {urt, hilo, br, mem, ld, wen, wd, rt, rs};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    in_valid = 2'b00;
    stall    = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic push2(input logic [20:0] m0, input logic [63:0] d0,
                       input logic [20:0] m1, input logic [63:0] d1);
    in_valid = 2'b11;
    in_meta0 = m0; in_data0 = d0;
    in_meta1 = m1; in_data1 = d1;
  endtask

  task automatic push1(input logic [20:0] m0, input logic [63:0] d0);
    in_valid = 2'b01;
    in_meta0 = m0; in_data0 = d0;
  endtask

  initial begin
    resetn = 1'b0;
    idle();
    in_data0 = 64'd0; in_data1 = 64'd0; in_meta0 = 21'd0; in_meta1 = 21'd0;
    #1;
    check_eq("rst_count", 64'(count), 64'd0);
    check_eq("rst_ready", 64'(in_ready), 64'd1);
    check_eq("rst_iss0", 64'(iss0_valid), 64'd0);
    check_eq("rst_iss1", 64'(iss1_valid), 64'd0);
    tick(); tick();
    resetn = 1'b1;
    tick();

    // 1: two independent ALU ops dual-issue
    push2(mk(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), 64'hA0,
          mk(5'd4, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), 64'hA1);
    tick();
    idle(); #1;
    check_eq("t1_count2", 64'(count), 64'd2);
    check_eq("t1_iss0", 64'(iss0_valid), 64'd1);
    check_eq("t1_iss1", 64'(iss1_valid), 64'd1);
    check_eq("t1_d0", iss0_data, 64'hA0);
    check_eq("t1_d1", iss1_data, 64'hA1);
    check_eq("t6_se_iss0", 64'(se_iss0_valid), 64'd1);
    check_eq("t6_se_iss1", 64'(se_iss1_valid), 64'd0);
    tick();
    check_eq("t1_count0", 64'(count), 64'd0);
    check_eq("t6_se_count", 64'(se_count), 64'd1);

    // 2: head writes r8, head+1 reads r8 via rt -> no pairing
    push2(mk(5'd1, 5'd2, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), 64'hB0,
          mk(5'd3, 5'd8, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), 64'hB1);
    tick();
    idle(); #1;
    check_eq("t2_iss0", 64'(iss0_valid), 64'd1);
    check_eq("t2_iss1_raw", 64'(iss1_valid), 64'd0);
    check_eq("t2_d0", iss0_data, 64'hB0);
    tick();
    check_eq("t2_iss0_next", 64'(iss0_valid), 64'd1);
    check_eq("t2_d0_next", iss0_data, 64'hB1);
    check_eq("t6_cnt1_iss1", 64'(iss1_valid), 64'd0);
    tick();
    check_eq("t2_count0", 64'(count), 64'd0);

    // 3: load r9 then consumer rs=9 -> two bubbles
    push2(mk(5'd1, 5'd0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0), 64'hC0,
          mk(5'd9, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 64'hC1);
    tick();
    idle(); #1;
    check_eq("t3_ld_iss", 64'(iss0_valid), 64'd1);
    check_eq("t3_ld_nopair", 64'(iss1_valid), 64'd0);
    tick();
    check_eq("t3_bubble1", 64'(iss0_valid), 64'd0);
    tick();
    check_eq("t3_bubble2", 64'(iss0_valid), 64'd0);
    tick();
    check_eq("t3_use_iss", 64'(iss0_valid), 64'd1);
    check_eq("t3_use_data", iss0_data, 64'hC1);
    tick();
    check_eq("t3_count0", 64'(count), 64'd0);
    // load to r0 never interlocks
    push1(mk(5'd1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0), 64'hC2);
    tick();
    push1(mk(5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), 64'hC3);
    #1;
    check_eq("t3_ld0_iss", 64'(iss0_valid), 64'd1);
    tick();
    idle(); #1;
    check_eq("t3_r0_noint", 64'(iss0_valid), 64'd1);
    check_eq("t3_r0_data", iss0_data, 64'hC3);
    tick();

    // 4: fill under stall across pointer wrap, then drain in order
    stall = 1'b1;
    for (int k = 0; k < 7; k++) begin
      push2(mk(5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), 64'h100 + 64'(2*k),
            mk(5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), 64'h101 + 64'(2*k));
      tick();
    end
    in_valid = 2'b00; #1;
    check_eq("t4_count14", 64'(count), 64'd14);
    check_eq("t4_ready14", 64'(in_ready), 64'd1);
    check_eq("t4_stall_iss", 64'(iss0_valid), 64'd0);
    push1(mk(5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), 64'h10E);
    tick();
    in_valid = 2'b00; #1;
    check_eq("t4_count15", 64'(count), 64'd15);
    check_eq("t4_ready15", 64'(in_ready), 64'd0);
    push2(21'd0, 64'hBAD, 21'd0, 64'hBAD);
    tick();
    idle(); #1;
    check_eq("t4_dropped", 64'(count), 64'd15);
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      check_eq("t4_drain_v0", 64'(iss0_valid), 64'd1);
      check_eq("t4_drain_d0", iss0_data, 64'h100 + 64'(idx));
      if (idx + 1 < 15) begin
        check_eq("t4_drain_v1", 64'(iss1_valid), 64'd1);
        check_eq("t4_drain_d1", iss1_data, 64'h101 + 64'(idx));
        idx = idx + 2;
      end else begin
        check_eq("t4_drain_v1_last", 64'(iss1_valid), 64'd0);
        idx = idx + 1;
      end
      tick();
    end
    check_eq("t4_count0", 64'(count), 64'd0);

    // 5: flush with load in scoreboard and occupancy 6
    push1(mk(5'd1, 5'd0, 5'd10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0), 64'hD0);
    tick();
    push2(mk(5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), 64'hD1,
          mk(5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), 64'hD2);
    #1;
    check_eq("t5_ld_iss", 64'(iss0_valid), 64'd1);
    tick();
    stall = 1'b1;
    tick();
    tick();
    in_valid = 2'b00; #1;
    check_eq("t5_count6", 64'(count), 64'd6);
    stall = 1'b0; flush = 1'b1;
    push2(21'd0, 64'hEE, 21'd0, 64'hEF);
    #1;
    check_eq("t5_flush_iss0", 64'(iss0_valid), 64'd0);
    check_eq("t5_flush_iss1", 64'(iss1_valid), 64'd0);
    tick();
    idle(); #1;
    check_eq("t5_count0", 64'(count), 64'd0);
    check_eq("t5_ready", 64'(in_ready), 64'd1);
    push1(mk(5'd10, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 64'hD9);
    tick();
    idle(); #1;
    check_eq("t5_dep_iss", 64'(iss0_valid), 64'd1);
    check_eq("t5_dep_data", iss0_data, 64'hD9);
    tick();

    // 6: head+1 that is mem/branch/hilo never takes the slave slot
    for (int k = 0; k < 3; k++) begin
      push2(mk(5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), 64'hE0 + 64'(k),
            mk(5'd3, 5'd4, 5'd0, 1'b0, 1'b0, (k == 0), (k == 1), (k == 2), 1'b1),
            64'hF0 + 64'(k));
      tick();
      idle(); #1;
      check_eq("t6_class_iss0", 64'(iss0_valid), 64'd1);
      check_eq("t6_class_iss1", 64'(iss1_valid), 64'd0);
      tick();
      check_eq("t6_class_next", iss0_data, 64'hF0 + 64'(k));
      tick();
    end
    check_eq("t6_count0", 64'(count), 64'd0);

    // async reset mid-cycle
    stall = 1'b1;
    push2(mk(5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), 64'h11,
          mk(5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), 64'h12);
    tick();
    idle(); #1;
    check_eq("ar_pre_iss", 64'(iss0_valid), 64'd1);
    resetn = 1'b0; #1;
    check_eq("ar_count", 64'(count), 64'd0);
    check_eq("ar_iss0", 64'(iss0_valid), 64'd0);
    check_eq("ar_ready", 64'(in_ready), 64'd1);
    resetn = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
